mailbox: RTL and testbench
==========================

Name: mailbox

Overview:
- Receive-side counterpart of the send path. Accepts incoming messages from the loopback interceptor and buffers them in an in-order FIFO.
- Serves receive-queue requests: RECV pops the oldest message, gated by the commit safety unit; AVAIL reports the current occupancy.
- Returns results through a single writeback holding register toward the writeback arbiter.

Parameters:
- DEPTH, 4, number of message buffer entries; must be a power of two and >= 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous pipeline flush
- loopback_mailbox_valid  in  1  incoming message valid
- mailbox_loopback_ready  out  1  buffer can accept a message
- loopback_mailbox_data  in  $bits(interface_recv_data_t)  incoming message
- receive_queue_mailbox_valid  in  1  receive request valid
- mailbox_receive_queue_ready  out  1  request consumed this cycle
- receive_queue_mailbox_data  in  $bits(receive_queue_data_t)  opcode, register, passthrough
- mailbox_writeback_arbiter_valid  out  1  holding register occupied
- writeback_arbiter_mailbox_acknowledge  in  1  arbiter took the holding register
- mailbox_writeback_arbiter_data  out  $bits(writeback_arbiter_data_t)  register, value, passthrough
- mailbox_csu_request  out  $bits(commit_safety_request_t)  payload = passthrough.gl_index (XCTCMSG_SARGANTANA builds only)
- csu_mailbox_grant  in  1  RECV is non-speculative and may pop

Behaviour:
- Reset (async, rst=1): FIFO empty, read/write pointers 0, count 0, writeback_valid 0. Output values during reset:
  - mailbox_loopback_ready = 1
  - mailbox_receive_queue_ready = 0
  - mailbox_writeback_arbiter_valid = 0
- Reset may assert at any cycle. Any in-flight message or request is dropped; the bench reissues.
- Push: mailbox_loopback_ready = (count != DEPTH). The ready output has no combinational dependency on pop.
  - A full FIFO refuses a push even when a pop occurs in the same cycle.
  - On valid&ready, loopback_mailbox_data.message is written at the write pointer, which then increments mod DEPTH.
- No bypass: a pushed message becomes poppable the next cycle, so arrival-to-RECV latency is at least 1.
- Writeback allocatable = !writeback_valid | acknowledge.
- RECV (opcode RECV_OP):
  - ready = allocatable & (count != 0) & csu_mailbox_grant.
  - On valid&ready: pop the head, read pointer +1 mod DEPTH, and load the holding register with value = message.payload, register, and passthrough.
  - While the FIFO is empty the request is held (blocking). The bench holds valid asserted and request data stable until ready.
- AVAIL (opcode AVAIL_OP):
  - ready = allocatable; no CSU dependency and no pop.
  - value = zero-extended count as sampled in the acceptance cycle (before any same-cycle push).
- Count update: count +1 on push only, -1 on pop only, unchanged when both occur. The counter never exceeds DEPTH and never underflows.
- Writeback: valid is asserted from the cycle after allocation until the cycle of acknowledge, so acceptance-to-writeback latency is 1.
  - Acknowledge and a new allocation in the same cycle keep valid at 1, with the new data.
- Flush: clears writeback_valid only. FIFO contents, pointers and count are preserved, because arrivals are architectural.
  - A request presented in a flush cycle is not accepted: ready is forced to 0 while flush = 1.
- Pointer wrap: pointers are $clog2(DEPTH) bits; ordering is preserved across wrap.

Decomposition:
- xctcmsg_pkg holds:
  - interface_recv_data_t {message_t message}
  - receive_queue_data_t {mailbox_op_t opcode, register, passthrough}
  - the mailbox_op_t enum {RECV_OP, AVAIL_OP}
  - message_t, writeback_arbiter_data_t and commit_safety_request_t are reused from the same package.
- Sub-module: mailbox_fifo, a parametric synchronous FIFO with push/pop/count/full/empty, async active-high reset, and no flush input.

Test Plan:
- Push payloads 0xA1, 0xA2; then RECV to r5 with grant=1 -> writebacks {r5, 0xA1} then {r5, 0xA2} in order, count returns to 0.
- DEPTH=4: push 5 messages back-to-back -> ready drops after the 4th; the 5th is accepted only after a RECV pop. A same-cycle pop while full still sees ready=0.
- RECV on an empty buffer with grant=1 -> ready=0 until a push of 0x33; then ready=1 one cycle after the push, and writeback value=0x33.
- RECV with 2 messages queued, grant=0 for 3 cycles -> no pop and count stays 2; grant=1 -> pop occurs the same cycle.
- AVAIL with 3 messages queued and a simultaneous push -> writeback value=3; the next AVAIL returns 4.
- Holding register full, acknowledge withheld, then flush -> writeback_valid=0 next cycle and FIFO count unchanged. Async rst mid-traffic -> all outputs reach their reset values with no clock edge required.

Source files
------------

// File: rtl/xctcmsg_pkg.sv
// Shared types for the cross-core message path: message payloads, receive-queue
// requests, writeback records and commit-safety requests.
package xctcmsg_pkg;

    localparam int VALUE_W = 32;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        logic [7:0] gl_index;
        logic [3:0] tag;
    } passthrough_t;

    typedef struct packed {
        logic [VALUE_W-1:0] payload;
    } message_t;

    typedef enum logic [0:0] {
        RECV_OP  = 1'b0,
        AVAIL_OP = 1'b1
    } mailbox_op_t;

    typedef struct packed {
        message_t message;
    } interface_recv_data_t;

    typedef struct packed {
        mailbox_op_t  opcode;
        reg_idx_t     register;
        passthrough_t passthrough;
    } receive_queue_data_t;

    typedef struct packed {
        reg_idx_t           register;
        logic [VALUE_W-1:0] value;
        passthrough_t       passthrough;
    } writeback_arbiter_data_t;

    typedef struct packed {
        logic [7:0] gl_index;
    } commit_safety_request_t;

endpackage

// File: rtl/mailbox_fifo.sv
// In-order message buffer: power-of-two depth, wrapping pointers and an explicit
// occupancy counter so full and empty are unambiguous.
module mailbox_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Guard internally so the counter can never overflow or underflow.
    assign push_s = push_i & ~full_o;
    assign pop_s  = pop_i & ~empty_o;

    // Pointer and counter next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + 1'b1;
        end else if (pop_s && !push_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only meaningful where the counter says so.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mailbox.sv
// Receive-side mailbox: buffers loopback messages and serves RECV/AVAIL requests
// through a single writeback holding register.
module mailbox
    import xctcmsg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic                                        loopback_mailbox_valid,
    output logic                                        mailbox_loopback_ready,
    input  logic [$bits(interface_recv_data_t)-1:0]     loopback_mailbox_data,
    input  logic                                        receive_queue_mailbox_valid,
    output logic                                        mailbox_receive_queue_ready,
    input  logic [$bits(receive_queue_data_t)-1:0]      receive_queue_mailbox_data,
    output logic                                        mailbox_writeback_arbiter_valid,
    input  logic                                        writeback_arbiter_mailbox_acknowledge,
    output logic [$bits(writeback_arbiter_data_t)-1:0]  mailbox_writeback_arbiter_data,
    output logic [$bits(commit_safety_request_t)-1:0]   mailbox_csu_request,
    input  logic                                        csu_mailbox_grant
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    interface_recv_data_t    lb_s;
    receive_queue_data_t     rq_s;
    commit_safety_request_t  csu_s;
    message_t                head_s;
    logic [CNT_W-1:0]        count_s;
    logic                    full_s, empty_s;
    logic                    push_s, pop_s, accept_s, alloc_s, is_recv_s;
    logic                    wb_valid_q, wb_valid_d;
    writeback_arbiter_data_t wb_data_q, wb_data_d;

    assign lb_s = interface_recv_data_t'(loopback_mailbox_data);
    assign rq_s = receive_queue_data_t'(receive_queue_mailbox_data);

    assign is_recv_s = (rq_s.opcode == RECV_OP);
    assign alloc_s   = ~wb_valid_q | writeback_arbiter_mailbox_acknowledge;
    assign push_s    = loopback_mailbox_valid & ~full_s;

    // Push readiness depends only on occupancy, never on a same-cycle pop.
    assign mailbox_loopback_ready = ~full_s;

    // Request readiness; forced low during reset and flush.
    always_comb begin
        mailbox_receive_queue_ready = 1'b0;
        if (rst || flush) begin
            mailbox_receive_queue_ready = 1'b0;
        end else if (is_recv_s) begin
            mailbox_receive_queue_ready = alloc_s & ~empty_s & csu_mailbox_grant;
        end else begin
            mailbox_receive_queue_ready = alloc_s;
        end
    end

    assign accept_s = receive_queue_mailbox_valid & mailbox_receive_queue_ready;
    assign pop_s    = accept_s & is_recv_s;

    assign csu_s.gl_index = rq_s.passthrough.gl_index;
    assign mailbox_csu_request = csu_s;

    mailbox_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(message_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (lb_s.message),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    // Holding register next state; flush discards the pending result only.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (accept_s) begin
            wb_valid_d = 1'b1;
        end else if (writeback_arbiter_mailbox_acknowledge) begin
            wb_valid_d = 1'b0;
        end else begin
            wb_valid_d = wb_valid_q;
        end
        if (accept_s) begin
            wb_data_d.register    = rq_s.register;
            wb_data_d.passthrough = rq_s.passthrough;
            if (is_recv_s) begin
                wb_data_d.value = head_s.payload;
            end else begin
                wb_data_d.value = {{(VALUE_W - CNT_W){1'b0}}, count_s};
            end
        end else begin
            wb_data_d = wb_data_q;
        end
    end

    // Holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign mailbox_writeback_arbiter_valid = wb_valid_q;
    assign mailbox_writeback_arbiter_data  = wb_data_q;

endmodule

// File: tb/tb_mailbox.sv
// Directed self-checking bench for the mailbox (DEPTH = 4).
module tb_mailbox;
    import xctcmsg_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    logic lb_valid;
    logic lb_ready;
    interface_recv_data_t lb_data;
    logic rq_valid;
    logic rq_ready;
    receive_queue_data_t rq_data;
    logic wb_valid;
    logic ack;
    writeback_arbiter_data_t wb_data;
    commit_safety_request_t csu_req;
    logic grant;

    int tests;
    int fails;

    mailbox #(.DEPTH(4)) dut (
        .clk                                   (clk),
        .rst                                   (rst),
        .flush                                 (flush),
        .loopback_mailbox_valid                (lb_valid),
        .mailbox_loopback_ready                (lb_ready),
        .loopback_mailbox_data                 (lb_data),
        .receive_queue_mailbox_valid           (rq_valid),
        .mailbox_receive_queue_ready           (rq_ready),
        .receive_queue_mailbox_data            (rq_data),
        .mailbox_writeback_arbiter_valid       (wb_valid),
        .writeback_arbiter_mailbox_acknowledge (ack),
        .mailbox_writeback_arbiter_data        (wb_data),
        .mailbox_csu_request                   (csu_req),
        .csu_mailbox_grant                     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] p);
        lb_valid = 1'b1;
        lb_data.message.payload = p;
        cyc();
        lb_valid = 1'b0;
    endtask

    task automatic set_rq(input mailbox_op_t op, input logic [4:0] r, input logic [7:0] g);
        rq_valid = 1'b1;
        rq_data.opcode = op;
        rq_data.register = r;
        rq_data.passthrough.gl_index = g;
        rq_data.passthrough.tag = 4'h5;
    endtask

    task automatic drain();
        rq_valid = 1'b0;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    task automatic do_avail(output logic [31:0] v);
        set_rq(AVAIL_OP, 5'd0, 8'h00);
        cyc();
        rq_valid = 1'b0;
        v = wb_data.value;
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_rq(AVAIL_OP, 5'd1, 8'h00);
        cyc();
        cyc();
        tests++; if (lb_ready !== 1'b1) begin fails++; $display("FAIL reset_lb_ready: got %b expected 1", lb_ready); end
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL reset_rq_ready: got %b expected 0", rq_ready); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        rq_valid = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_in_order();
        logic [31:0] v;
        push1(32'hA1);
        push1(32'hA2);
        grant = 1'b1;
        set_rq(RECV_OP, 5'd5, 8'h11);
        #1;
        tests++; if (rq_ready !== 1'b1) begin fails++; $display("FAIL order_ready: got %b expected 1", rq_ready); end
        tests++; if (csu_req.gl_index !== 8'h11) begin fails++; $display("FAIL order_csu: got %0h expected 11", csu_req.gl_index); end
        cyc();
        tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'hA1 || wb_data.register !== 5'd5) begin
            fails++; $display("FAIL order_first: got v=%b val=%0h r=%0d expected 1 a1 5", wb_valid, wb_data.value, wb_data.register); end
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL order_busy: got %b expected 0", rq_ready); end
        ack = 1'b1;
        #1;
        tests++; if (rq_ready !== 1'b1) begin fails++; $display("FAIL order_ack_ready: got %b expected 1", rq_ready); end
        cyc();
        tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'hA2 || wb_data.register !== 5'd5) begin
            fails++; $display("FAIL order_second: got v=%b val=%0h r=%0d expected 1 a2 5", wb_valid, wb_data.value, wb_data.register); end
        drain();
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL order_drained: got %b expected 0", wb_valid); end
        do_avail(v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL order_count: got %0d expected 0", v); end
    endtask

    task automatic test_full();
        grant = 1'b1;
        lb_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lb_data.message.payload = 32'hB0 + 32'(k);
            #1;
            tests++; if (lb_ready !== 1'b1) begin fails++; $display("FAIL full_ready_%0d: got %b expected 1", k, lb_ready); end
            cyc();
        end
        lb_data.message.payload = 32'hB4;
        #1;
        tests++; if (lb_ready !== 1'b0) begin fails++; $display("FAIL full_refuse: got %b expected 0", lb_ready); end
        set_rq(RECV_OP, 5'd7, 8'h22);
        #1;
        tests++; if (rq_ready !== 1'b1 || lb_ready !== 1'b0) begin
            fails++; $display("FAIL full_same_cycle_pop: got rq=%b lb=%b expected 1 0", rq_ready, lb_ready); end
        cyc();
        tests++; if (wb_data.value !== 32'hB0) begin fails++; $display("FAIL full_pop_head: got %0h expected b0", wb_data.value); end
        tests++; if (lb_ready !== 1'b1) begin fails++; $display("FAIL full_after_pop: got %b expected 1", lb_ready); end
        rq_valid = 1'b0;
        ack = 1'b1;
        cyc();
        lb_valid = 1'b0;
        ack = 1'b0;
        #1;
        tests++; if (lb_ready !== 1'b0 || wb_valid !== 1'b0) begin
            fails++; $display("FAIL full_refilled: got lb=%b wb=%b expected 0 0", lb_ready, wb_valid); end
        set_rq(RECV_OP, 5'd7, 8'h22);
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'hB1 + 32'(i)) begin
                fails++; $display("FAIL full_order_%0d: got v=%b val=%0h expected 1 %0h", i, wb_valid, wb_data.value, 32'hB1 + 32'(i)); end
        end
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL full_empty_block: got %b expected 0", rq_ready); end
        drain();
    endtask

    task automatic test_empty_block();
        grant = 1'b1;
        set_rq(RECV_OP, 5'd3, 8'h33);
        #1;
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL empty_ready: got %b expected 0", rq_ready); end
        cyc();
        tests++; if (rq_ready !== 1'b0 || wb_valid !== 1'b0) begin
            fails++; $display("FAIL empty_held: got rq=%b wb=%b expected 0 0", rq_ready, wb_valid); end
        lb_valid = 1'b1;
        lb_data.message.payload = 32'h33;
        #1;
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL empty_no_bypass: got %b expected 0", rq_ready); end
        cyc();
        lb_valid = 1'b0;
        #1;
        tests++; if (rq_ready !== 1'b1) begin fails++; $display("FAIL empty_ready_after_push: got %b expected 1", rq_ready); end
        cyc();
        tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'h33) begin
            fails++; $display("FAIL empty_value: got v=%b val=%0h expected 1 33", wb_valid, wb_data.value); end
        drain();
    endtask

    task automatic test_grant();
        logic [31:0] v;
        push1(32'hC1);
        push1(32'hC2);
        grant = 1'b0;
        set_rq(RECV_OP, 5'd9, 8'h44);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL grant_held_%0d: got %b expected 0", i, rq_ready); end
            cyc();
        end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL grant_no_wb: got %b expected 0", wb_valid); end
        rq_valid = 1'b0;
        do_avail(v);
        tests++; if (v !== 32'd2) begin fails++; $display("FAIL grant_count: got %0d expected 2", v); end
        grant = 1'b1;
        set_rq(RECV_OP, 5'd9, 8'h44);
        #1;
        tests++; if (rq_ready !== 1'b1) begin fails++; $display("FAIL grant_ready: got %b expected 1", rq_ready); end
        cyc();
        tests++; if (wb_data.value !== 32'hC1) begin fails++; $display("FAIL grant_pop: got %0h expected c1", wb_data.value); end
        ack = 1'b1;
        cyc();
        tests++; if (wb_data.value !== 32'hC2) begin fails++; $display("FAIL grant_pop2: got %0h expected c2", wb_data.value); end
        drain();
    endtask

    task automatic test_avail();
        logic [31:0] v;
        push1(32'hD1);
        push1(32'hD2);
        push1(32'hD3);
        set_rq(AVAIL_OP, 5'd2, 8'h55);
        lb_valid = 1'b1;
        lb_data.message.payload = 32'hD4;
        cyc();
        lb_valid = 1'b0;
        rq_valid = 1'b0;
        tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'd3 || wb_data.register !== 5'd2) begin
            fails++; $display("FAIL avail_three: got v=%b val=%0d r=%0d expected 1 3 2", wb_valid, wb_data.value, wb_data.register); end
        drain();
        do_avail(v);
        tests++; if (v !== 32'd4) begin fails++; $display("FAIL avail_four: got %0d expected 4", v); end
        grant = 1'b1;
        set_rq(RECV_OP, 5'd1, 8'h00);
        ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests++; if (wb_data.value !== 32'hD1 + 32'(i)) begin
                fails++; $display("FAIL avail_pop_%0d: got %0h expected %0h", i, wb_data.value, 32'hD1 + 32'(i)); end
        end
        drain();
    endtask

    task automatic test_flush();
        logic [31:0] v;
        push1(32'hE1);
        push1(32'hE2);
        grant = 1'b1;
        ack = 1'b0;
        set_rq(RECV_OP, 5'd4, 8'h66);
        cyc();
        rq_valid = 1'b0;
        tests++; if (wb_valid !== 1'b1 || wb_data.value !== 32'hE1) begin
            fails++; $display("FAIL flush_loaded: got v=%b val=%0h expected 1 e1", wb_valid, wb_data.value); end
        flush = 1'b1;
        set_rq(AVAIL_OP, 5'd4, 8'h66);
        ack = 1'b1;
        #1;
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b expected 0", rq_ready); end
        cyc();
        flush = 1'b0;
        rq_valid = 1'b0;
        ack = 1'b0;
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_cleared: got %b expected 0", wb_valid); end
        do_avail(v);
        tests++; if (v !== 32'd1) begin fails++; $display("FAIL flush_count: got %0d expected 1", v); end
        set_rq(RECV_OP, 5'd4, 8'h66);
        cyc();
        tests++; if (wb_data.value !== 32'hE2) begin fails++; $display("FAIL flush_kept: got %0h expected e2", wb_data.value); end
        drain();
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) push1(32'hF0 + 32'(k));
        ack = 1'b0;
        set_rq(AVAIL_OP, 5'd6, 8'h77);
        cyc();
        tests++; if (wb_valid !== 1'b1 || lb_ready !== 1'b0) begin
            fails++; $display("FAIL areset_pre: got wb=%b lb=%b expected 1 0", wb_valid, lb_ready); end
        ack = 1'b1;
        lb_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        tests++; if (lb_ready !== 1'b1) begin fails++; $display("FAIL areset_lb_ready: got %b expected 1", lb_ready); end
        tests++; if (rq_ready !== 1'b0) begin fails++; $display("FAIL areset_rq_ready: got %b expected 0", rq_ready); end
        tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL areset_wb_valid: got %b expected 0", wb_valid); end
        rq_valid = 1'b0;
        ack = 1'b0;
        lb_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        do_avail(v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL areset_count: got %0d expected 0", v); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        flush = 1'b0;
        lb_valid = 1'b0;
        lb_data = '0;
        rq_valid = 1'b0;
        rq_data = '0;
        ack = 1'b0;
        grant = 1'b0;
        test_reset();
        test_in_order();
        test_full();
        test_empty_block();
        test_grant();
        test_avail();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
